fetch_unit: RTL and testbench

Instruction fetch stage of the kleine-riscv pipeline, and the producer side of the fetch→decode interface. It holds the program counter and issues single-outstanding word requests to instruction memory. Each returned instruction is presented to decode as a registered pc/next_pc/instruction/valid bundle, held stable while the hazard unit stalls. Taken branches, jumps and traps from execute redirect the PC and flush any in-flight or buffered instruction.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word request outstanding
// to instruction memory, and presents a registered pc/next_pc/instr/valid
// bundle to decode. A one-entry skid buffer absorbs a response that lands
// while decode is stalled. Redirects flush in-flight and buffered words.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_data_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_address,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_instr_q;
  logic        discard_q;
  logic [31:0] pc_out_q;
  logic [31:0] next_pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  logic [31:0] target_d;
  logic        slot_free_d;
  logic        consume_d;

  // Redirect target is always word aligned; low bits are simply masked off.
  assign target_d    = branch_address & 32'hFFFF_FFFC;
  // The output slot can take a new bundle when empty or being consumed.
  assign slot_free_d = !valid_q || !stall;
  assign consume_d   = valid_q && !stall;

  assign fetch_valid     = (state_q == S_REQ);
  assign fetch_address   = pc_q;
  assign pc_out          = pc_out_q;
  assign next_pc_out     = next_pc_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

  // Fetch FSM with request tracking, skid buffer and registered decode bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_VECTOR;
      req_pc_q    <= 32'h0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      discard_q   <= 1'b0;
      pc_out_q    <= 32'h0;
      next_pc_q   <= 32'h0;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
    end else if (branch) begin
      // Redirect wins over everything; clearing valid even under stall
      // keeps an old-path instruction from ever reaching decode.
      pc_q    <= target_d;
      valid_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          // An accepted old-path request still owes a response: drop it later.
          if (fetch_ready) begin
            discard_q <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fetch_data_valid) begin
            discard_q <= 1'b0;
            state_q   <= S_REQ;
          end else begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      // Consumed bundle is retired unless replaced below in the same cycle.
      if (state_q != S_FULL && consume_d) valid_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (fetch_ready) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fetch_data_valid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end else if (slot_free_d) begin
              pc_out_q  <= req_pc_q;
              next_pc_q <= req_pc_q + 32'd4;
              instr_q   <= fetch_data;
              valid_q   <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              buf_pc_q    <= req_pc_q;
              buf_instr_q <= fetch_data;
              state_q     <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            pc_out_q  <= buf_pc_q;
            next_pc_q <= buf_pc_q + 32'd4;
            instr_q   <= buf_instr_q;
            valid_q   <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable instruction memory model, an
// epoch-tagged scoreboard of expected bundles, and a table of redirect cases.
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        fetch_data_valid;
  logic        stall;
  logic        branch;
  logic [31:0] branch_address;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .fetch_data_valid(fetch_data_valid),
    .stall(stall), .branch(branch), .branch_address(branch_address),
    .pc_out(pc_out), .next_pc_out(next_pc_out),
    .instruction_out(instruction_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model and scoreboard state
  int          lat = 1;
  int          rdy_block = 0;
  bit          mpend = 0;
  int          mcnt = 0;
  logic [31:0] maddr = 32'h0;
  int          mep = 0;
  int          epoch = 0;
  logic [31:0] exp_fa = RV;
  logic [31:0] sbq[$];
  int          n_cons = 0;
  bit          hold_v = 0;
  logic [31:0] h_pc, h_npc, h_in;

  // Memory drives at negedge; at negedge+2 the model books what the coming
  // posedge will do (inputs and DUT outputs are stable until then).
  initial begin
    logic [31:0] e;
    fetch_ready = 1'b0;
    fetch_data_valid = 1'b0;
    fetch_data = 32'h0;
    forever begin
      @(negedge clk);
      fetch_ready = (rdy_block == 0);
      if (rdy_block > 0) rdy_block--;
      fetch_data_valid = mpend && (mcnt == 1);
      fetch_data = fetch_data_valid ? memf(maddr) : 32'hDEAD_BEEF;
      #2;
      if (!rst_n) begin
        mpend = 0;
        sbq.delete();
        exp_fa = RV;
        hold_v = 0;
      end else begin
        if (hold_v) begin
          chk("hold_pc", pc_out, h_pc);
          chk("hold_npc", next_pc_out, h_npc);
          chk("hold_instr", instruction_out, h_in);
          chk("hold_valid", {31'h0, valid_out}, 32'h1);
        end
        hold_v = valid_out && stall && !branch;
        h_pc = pc_out; h_npc = next_pc_out; h_in = instruction_out;
        if (valid_out && !stall) begin
          n_cons++;
          if (sbq.size() == 0) begin
            nchk++; errs++;
            $display("FAIL unexpected_bundle: got pc %h expected none", pc_out);
          end else begin
            e = sbq.pop_front();
            chk("bundle_pc", pc_out, e);
            chk("bundle_npc", next_pc_out, e + 32'd4);
            chk("bundle_instr", instruction_out, memf(e));
          end
        end
        if (mpend && fetch_data_valid) begin
          mpend = 0;
          if (mep == epoch) sbq.push_back(maddr);
        end else if (mpend) begin
          mcnt--;
        end
        if (fetch_valid && fetch_ready) begin
          chk("fetch_addr", fetch_address, exp_fa);
          exp_fa = exp_fa + 32'd4;
          if (mpend) begin
            nchk++; errs++;
            $display("FAIL outstanding: got 2 requests expected 1");
          end
          mpend = 1; maddr = fetch_address; mep = epoch; mcnt = lat;
        end
        if (branch) begin
          epoch++;
          sbq.delete();
          exp_fa = branch_address & 32'hFFFF_FFFC;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int          mode;   // 0 WAIT no resp, 1 with accept, 2 stall+FULL, 3 REQUEST unaccepted
    int          k;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
  } vec_t;

  function automatic bit cond_met(input int mode);
    case (mode)
      0: return !fetch_valid && mpend && !fetch_data_valid;
      1: return fetch_valid && fetch_ready;
      2: return !fetch_valid && !mpend && valid_out;
      default: return fetch_valid && !fetch_ready;
    endcase
  endfunction

  initial begin
    vec_t tbl[5];
    int   n0, t;
    logic [31:0] a;
    tbl[0] = '{0, 3, 32'h8000_0103, 32'h8000_0100, 32'h8000_0104};
    tbl[1] = '{1, 1, 32'h8000_0200, 32'h8000_0200, 32'h8000_0204};
    tbl[2] = '{2, 1, 32'h8000_0300, 32'h8000_0300, 32'h8000_0304};
    tbl[3] = '{3, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[4] = '{0, 2, 32'h0000_0006, 32'h0000_0004, 32'h0000_0008};

    stall = 1'b0; branch = 1'b0; branch_address = 32'h0;
    repeat (2) step();
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_npc", next_pc_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h1);
    chk("rst_fetch_addr", fetch_address, RV);

    // Streaming at k=1: one instruction every two cycles
    repeat (6) step();
    n0 = n_cons;
    repeat (20) step();
    chk("stream_rate", n_cons - n0, 32'd10);

    // Stall long enough for a response to land in the skid buffer
    stall = 1'b1;
    repeat (5) step();
    chk("full_no_req", {31'h0, fetch_valid}, 32'h0);
    chk("full_valid", {31'h0, valid_out}, 32'h1);
    stall = 1'b0;
    repeat (6) step();

    // Backpressure: request held stable until accepted
    t = 0;
    while (!(!fetch_valid && mpend) && t < 100) begin step(); t++; end
    chk("bp_wait_timeout", t < 100, 32'h1);
    rdy_block = 4;
    step();
    chk("bp_valid0", {31'h0, fetch_valid}, 32'h1);
    a = fetch_address;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {31'h0, fetch_valid}, 32'h1);
      chk("bp_addr", fetch_address, a);
    end
    repeat (6) step();

    // Redirect cases
    for (int i = 0; i < 5; i++) begin
      lat = tbl[i].k;
      if (tbl[i].mode == 2) stall = 1'b1;
      if (tbl[i].mode == 3) rdy_block = 3;
      t = 0;
      while (!cond_met(tbl[i].mode) && t < 100) begin step(); t++; end
      chk("redir_cond_timeout", t < 100, 32'h1);
      branch = 1'b1;
      branch_address = tbl[i].tgt;
      step();
      branch = 1'b0;
      chk("redir_flush", {31'h0, valid_out}, 32'h0);
      stall = 1'b0;
      t = 0;
      while (!valid_out && t < 100) begin step(); t++; end
      chk("redir_valid_timeout", t < 100, 32'h1);
      chk("redir_pc", pc_out, tbl[i].exp_pc);
      chk("redir_npc", next_pc_out, tbl[i].exp_npc);
      chk("redir_instr", instruction_out, memf(tbl[i].exp_pc));
      repeat (6) step();
    end

    // Reset in the middle of a stream
    lat = 1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'h0, valid_out}, 32'h0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_addr", fetch_address, RV);
    step();
    rst_n = 1'b1;
    n0 = n_cons;
    repeat (12) step();
    chk("mrst_resume", n_cons > n0, 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
